fp_add_normalizer: RTL and testbench

FP_ADD_NORMALIZER -- requirements
Module: fp_add_normalizer

---
 rtl/fp_add_normalizer.sv | 187 ++++++++++++++++++
 tb/tb_fp_add_normalizer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalizer.sv
// FP32 adder back end: mantissa add/subtract followed by a
// one-bit-per-cycle normalizer with truncation and valid/ready handshakes.
module fp_add_normalizer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign_big,
   input  logic        sign_small,
   input  logic [7:0]  exp_big,
   input  logic [23:0] mant_big,
   input  logic [23:0] mant_small,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_sign_big;
   logic        r_sign_small;
   logic [23:0] r_mant_big;
   logic [23:0] r_mant_small;
   logic [7:0]  r_exp;
   logic [24:0] r_sum;
   logic        r_sign;
   logic [31:0] r_result;
   logic        r_overflow;
   logic        r_zero;

   logic        w_sign_big_nxt;
   logic        w_sign_small_nxt;
   logic [23:0] w_mant_big_nxt;
   logic [23:0] w_mant_small_nxt;
   logic [7:0]  w_exp_nxt;
   logic [24:0] w_sum_nxt;
   logic        w_sign_nxt;
   logic [31:0] w_result_nxt;
   logic        w_overflow_nxt;
   logic        w_zero_nxt;

   logic [7:0]  w_exp_inc;
   logic [24:0] w_sum_shr;
   logic        w_big_ge;

   assign w_exp_inc = r_exp + 8'd1;
   assign w_sum_shr = {1'b0, r_sum[24:1]};
   assign w_big_ge  = (r_mant_big >= r_mant_small);

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign overflow  = r_overflow;
   assign zero      = r_zero;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath update for each FSM step
   always_comb begin
      w_state_nxt      = r_state;
      w_sign_big_nxt   = r_sign_big;
      w_sign_small_nxt = r_sign_small;
      w_mant_big_nxt   = r_mant_big;
      w_mant_small_nxt = r_mant_small;
      w_exp_nxt        = r_exp;
      w_sum_nxt        = r_sum;
      w_sign_nxt       = r_sign;
      w_result_nxt     = r_result;
      w_overflow_nxt   = r_overflow;
      w_zero_nxt       = r_zero;

      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_sign_big_nxt   = sign_big;
               w_sign_small_nxt = sign_small;
               w_exp_nxt        = exp_big;
               w_mant_big_nxt   = mant_big;
               w_mant_small_nxt = mant_small;
               w_state_nxt      = S_ADD;
            end
         end
         S_ADD: begin
            if (r_sign_big == r_sign_small) begin
               w_sum_nxt  = {1'b0, r_mant_big} + {1'b0, r_mant_small};
               w_sign_nxt = r_sign_big;
            end else if (w_big_ge) begin
               w_sum_nxt  = {1'b0, r_mant_big - r_mant_small};
               w_sign_nxt = r_sign_big;
            end else begin
               w_sum_nxt  = {1'b0, r_mant_small - r_mant_big};
               w_sign_nxt = r_sign_small;
            end
            w_state_nxt = S_NORM;
         end
         S_NORM: begin
            // Carry out, cancellation, normalized, then left shift
            if (r_sum[24]) begin
               w_sum_nxt   = w_sum_shr;
               w_exp_nxt   = w_exp_inc;
               w_state_nxt = S_DONE;
               if (w_exp_inc == 8'hFF) begin
                  w_result_nxt   = {r_sign, 8'hFF, 23'd0};
                  w_overflow_nxt = 1'b1;
                  w_zero_nxt     = 1'b0;
               end else begin
                  w_result_nxt   = {r_sign, w_exp_inc, w_sum_shr[22:0]};
                  w_overflow_nxt = 1'b0;
                  w_zero_nxt     = 1'b0;
               end
            end else if (r_sum == 25'd0) begin
               w_result_nxt   = 32'd0;
               w_overflow_nxt = 1'b0;
               w_zero_nxt     = 1'b1;
               w_state_nxt    = S_DONE;
            end else if (r_sum[23]) begin
               w_result_nxt   = {r_sign, r_exp, r_sum[22:0]};
               w_overflow_nxt = 1'b0;
               w_zero_nxt     = 1'b0;
               w_state_nxt    = S_DONE;
            end else if (r_exp == 8'd1) begin
               // Result would be subnormal: flush to +0
               w_result_nxt   = 32'd0;
               w_overflow_nxt = 1'b0;
               w_zero_nxt     = 1'b1;
               w_state_nxt    = S_DONE;
            end else begin
               w_sum_nxt = {r_sum[23:0], 1'b0};
               w_exp_nxt = r_exp - 8'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath registers; reset clears the visible outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sign_big   <= 1'b0;
         r_sign_small <= 1'b0;
         r_mant_big   <= 24'd0;
         r_mant_small <= 24'd0;
         r_exp        <= 8'd0;
         r_sum        <= 25'd0;
         r_sign       <= 1'b0;
         r_result     <= 32'd0;
         r_overflow   <= 1'b0;
         r_zero       <= 1'b0;
      end else begin
         r_sign_big   <= w_sign_big_nxt;
         r_sign_small <= w_sign_small_nxt;
         r_mant_big   <= w_mant_big_nxt;
         r_mant_small <= w_mant_small_nxt;
         r_exp        <= w_exp_nxt;
         r_sum        <= w_sum_nxt;
         r_sign       <= w_sign_nxt;
         r_result     <= w_result_nxt;
         r_overflow   <= w_overflow_nxt;
         r_zero       <= w_zero_nxt;
      end
   end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed-vector bench for fp_add_normalizer: table of operand sets with
// hand-computed sums and latencies, plus backpressure and reset sequences.
module tb_fp_add_normalizer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        sign_big;
   logic        sign_small;
   logic [7:0]  exp_big;
   logic [23:0] mant_big;
   logic [23:0] mant_small;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        zero;

   int n_tests;
   int n_fail;

   fp_add_normalizer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sign_big   (sign_big),
      .sign_small (sign_small),
      .exp_big    (exp_big),
      .mant_big   (mant_big),
      .mant_small (mant_small),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .overflow   (overflow),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sb;
      logic        ss;
      logic [7:0]  e;
      logic [23:0] mb;
      logic [23:0] ms;
      logic [31:0] res;
      logic        ovf;
      logic        zr;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Offer an operand set, wait for out_valid; returns edges since accept
   task automatic launch(input vec_t v, output int edges);
      @(negedge clk);
      sign_big   = v.sb;
      sign_small = v.ss;
      exp_big    = v.e;
      mant_big   = v.mb;
      mant_small = v.ms;
      in_valid   = 1'b1;
      check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      edges = 0;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
      check("out_valid_after_release", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int   edges;
      vec_t v;
      logic [31:0] held;
      logic        seen;

      n_tests    = 0;
      n_fail     = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      sign_big   = 1'b0;
      sign_small = 1'b0;
      exp_big    = 8'd0;
      mant_big   = 24'd0;
      mant_small = 24'd0;

      //          sb    ss    exp     mant_big    mant_small  result        ovf   zero lat
      vecs[0]  = '{1'b0, 1'b0, 8'd127, 24'h800000, 24'h800000, 32'h40000000, 1'b0, 1'b0, 2};
      vecs[1]  = '{1'b0, 1'b1, 8'd127, 24'hC00000, 24'h800000, 32'h3F000000, 1'b0, 1'b0, 3};
      vecs[2]  = '{1'b0, 1'b1, 8'd127, 24'h800000, 24'hC00000, 32'hBF000000, 1'b0, 1'b0, 3};
      vecs[3]  = '{1'b0, 1'b1, 8'd127, 24'h9A0000, 24'h9A0000, 32'h00000000, 1'b0, 1'b1, 2};
      vecs[4]  = '{1'b0, 1'b0, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 32'h7F800000, 1'b1, 1'b0, 2};
      vecs[5]  = '{1'b1, 1'b1, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 32'hFF800000, 1'b1, 1'b0, 2};
      vecs[6]  = '{1'b0, 1'b0, 8'd253, 24'hFFFFFF, 24'hFFFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 2};
      vecs[7]  = '{1'b0, 1'b0, 8'd128, 24'h800000, 24'h400000, 32'h40400000, 1'b0, 1'b0, 2};
      vecs[8]  = '{1'b0, 1'b0, 8'd127, 24'h800001, 24'h800000, 32'h40000000, 1'b0, 1'b0, 2};
      vecs[9]  = '{1'b0, 1'b1, 8'd127, 24'h800001, 24'h800000, 32'h34000000, 1'b0, 1'b0, 25};
      vecs[10] = '{1'b0, 1'b1, 8'd10,  24'h800001, 24'h800000, 32'h00000000, 1'b0, 1'b1, 11};

      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      check("reset_zero", {31'd0, zero}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         launch(vecs[i], edges);
         check($sformatf("v%0d_latency", i), edges, vecs[i].lat);
         check($sformatf("v%0d_result", i), result, vecs[i].res);
         check($sformatf("v%0d_overflow", i), {31'd0, overflow},
               {31'd0, vecs[i].ovf});
         check($sformatf("v%0d_zero", i), {31'd0, zero},
               {31'd0, vecs[i].zr});
         release_out();
      end

      // Backpressure: DONE holds while a new operand set is offered
      v = vecs[1];
      launch(v, edges);
      check("bp_result", result, 32'h3F000000);
      held = result;
      @(negedge clk);
      in_valid = 1'b1;
      mant_big = 24'h123456;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_stable_%0d", c), result, held);
         check($sformatf("bp_in_ready_%0d", c), {31'd0, in_ready}, 32'd0);
         check($sformatf("bp_out_valid_%0d", c), {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      release_out();

      // Reset on the second NORM cycle of a long normalization
      v = vecs[9];
      @(negedge clk);
      sign_big   = v.sb;
      sign_small = v.ss;
      exp_big    = v.e;
      mant_big   = v.mb;
      mant_small = v.ms;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("mid_busy_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("mid_rst_result", result, 32'd0);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("mid_rst_no_output", {31'd0, seen}, 32'd0);

      // Block still works after the abandoned operation
      launch(vecs[0], edges);
      check("post_rst_latency", edges, 2);
      check("post_rst_result", result, 32'h40000000);
      release_out();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
